bcd_updown_counter: RTL and testbench

- Parametrised successor to the board's two-digit preload up/down counter.
- Counts at a divided rate using a single-clock tick enable; no derived clocks.
- Supports a loadable limit, three count modes (wrap, bounce, stop) and edge-detected direction toggling.
- Drives DIGITS seven-segment displays with decimal digits.

---
 rtl/bcd_updown_counter.sv | 157 +++++++++++++++
 tb/tb_bcd_updown_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Two-digit (parametrisable) BCD-display up/down counter.
// Steps at a divided tick rate. Supports a loadable limit, wrap/bounce/stop
// modes and edge-detected direction toggling. The display is a registered
// active-low seven-segment image of the decimal count.
module bcd_updown_counter #(
  parameter int WIDTH     = 6,
  parameter int DIGITS    = 2,
  parameter int DIV       = 12499999,
  parameter int LIMIT_RST = 59
) (
  input  logic                  clk_50MHz,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  dir_toggle,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  load_limit,
  output logic [WIDTH-1:0]      count,
  output logic                  count_up,
  output logic                  tick,
  output logic                  at_limit,
  output logic                  at_zero,
  output logic [7*DIGITS-1:0]   disp
);

  localparam int                DIV_W       = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam logic [DIV_W-1:0]  DIV_TC      = DIV_W'(DIV);
  localparam int unsigned       LIMIT_MAX   = 10**DIGITS - 1;
  localparam logic [WIDTH-1:0]  LIMIT_MAX_W = WIDTH'(LIMIT_MAX);
  localparam logic [WIDTH-1:0]  ONE_W       = WIDTH'(1);

  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_STOP   = 2'b10;

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 tick_q, tick_d;
  logic                 dir_toggle_q;
  logic [WIDTH-1:0]     count_q, count_d;
  logic                 count_up_q, count_up_d;
  logic [WIDTH-1:0]     limit_q, limit_d;
  logic [7*DIGITS-1:0]  disp_q, disp_d;

  logic                 toggle_edge;
  logic                 reverse;
  logic                 hit_limit;
  logic                 hit_zero;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign toggle_edge = dir_toggle && !dir_toggle_q;
  assign hit_limit   = (count_q >= limit_q);
  assign hit_zero    = (count_q == '0);

  // Free-running tick divider: tick is high in the cycle after div_cnt hits DIV.
  always_comb begin
    tick_d    = (div_cnt_q == DIV_TC);
    div_cnt_d = (div_cnt_q == DIV_TC) ? '0 : div_cnt_q + 1'b1;
  end

  // Limit capture, saturated to the largest value the display can show.
  always_comb begin
    limit_d = limit_q;
    if (load_limit) begin
      limit_d = (32'(limit) > LIMIT_MAX) ? LIMIT_MAX_W : limit;
    end
  end

  // Next count and direction; a toggle edge and a bounce reversal both invert.
  always_comb begin
    count_d = count_q;
    reverse = 1'b0;
    if (tick_q && ena) begin
      if (count_up_q) begin
        if (!hit_limit) begin
          count_d = count_q + ONE_W;
        end else begin
          case (mode)
            MODE_BOUNCE: begin
              count_d = (limit_q == '0) ? '0 : limit_q - ONE_W;
              reverse = 1'b1;
            end
            MODE_STOP: count_d = limit_q;
            default:   count_d = '0;
          endcase
        end
      end else begin
        if (!hit_zero) begin
          count_d = count_q - ONE_W;
        end else begin
          case (mode)
            MODE_BOUNCE: begin
              count_d = (limit_q == '0) ? '0 : ONE_W;
              reverse = 1'b1;
            end
            MODE_STOP: count_d = '0;
            default:   count_d = limit_q;
          endcase
        end
      end
    end
    count_up_d = (toggle_edge || reverse) ? ~count_up_q : count_up_q;
  end

  // Decimal digit extraction and segment encoding of the current count.
  always_comb begin
    int unsigned pw;
    disp_d = '1;
    pw     = 1;
    for (int i = 0; i < DIGITS; i++) begin
      disp_d[7*i +: 7] = seg7(4'((32'(count_q) / pw) % 10));
      pw = pw * 10;
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      div_cnt_q    <= '0;
      tick_q       <= 1'b0;
      dir_toggle_q <= 1'b0;
      count_q      <= '0;
      count_up_q   <= 1'b1;
      limit_q      <= WIDTH'(LIMIT_RST);
      disp_q       <= '1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      tick_q       <= tick_d;
      dir_toggle_q <= dir_toggle;
      count_q      <= count_d;
      count_up_q   <= count_up_d;
      limit_q      <= limit_d;
      disp_q       <= disp_d;
    end
  end

  assign count    = count_q;
  assign count_up = count_up_q;
  assign tick     = tick_q;
  assign at_limit = hit_limit;
  assign at_zero  = hit_zero;
  assign disp     = disp_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: directed scenarios plus random traffic,
// compared cycle by cycle against an arithmetic reference model.
module tb_bcd_updown_counter;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b1, ena = 1'b1, dir_toggle = 1'b0, load_limit = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [5:0]  limit = '0;
  logic [5:0]  count;
  logic        count_up, tick, at_limit, at_zero;
  logic [13:0] disp;

  // second instance, wide enough to exercise limit saturation at 99
  logic        b_rst = 1'b1, b_ena = 1'b0, b_dt = 1'b0, b_load = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic [6:0]  b_limit = '0;
  logic [6:0]  b_count;
  logic        b_up, b_tick, b_atl, b_atz;
  logic [13:0] b_disp;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000};

  // reference model state
  int          m_phase = 0, m_count = 0, m_lim = 59;
  bit          m_tick = 0, m_up = 1, m_dtq = 0;
  logic [13:0] m_disp = '1;

  bcd_updown_counter #(.WIDTH(6), .DIGITS(2), .DIV(2), .LIMIT_RST(59)) dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .ena(ena), .dir_toggle(dir_toggle),
    .mode(mode), .limit(limit), .load_limit(load_limit), .count(count),
    .count_up(count_up), .tick(tick), .at_limit(at_limit), .at_zero(at_zero),
    .disp(disp));

  bcd_updown_counter #(.WIDTH(7), .DIGITS(2), .DIV(2), .LIMIT_RST(59)) dut_wide (
    .clk_50MHz(clk_50MHz), .rst(b_rst), .ena(b_ena), .dir_toggle(b_dt),
    .mode(b_mode), .limit(b_limit), .load_limit(b_load), .count(b_count),
    .count_up(b_up), .tick(b_tick), .at_limit(b_atl), .at_zero(b_atz),
    .disp(b_disp));

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: compute the model's next state from the current inputs,
  // take the edge, then compare every output of the main instance.
  task automatic step();
    int          n_count, n_lim, n_phase;
    bit          n_tick, n_up, rev, edge_seen;
    logic [13:0] n_disp;
    if (rst) begin
      n_phase = 0; n_tick = 0; n_count = 0; n_up = 1; n_lim = 59; n_disp = '1;
    end else begin
      n_tick    = (m_phase == 2);
      n_phase   = (m_phase + 1) % 3;
      edge_seen = dir_toggle && !m_dtq;
      n_lim     = load_limit ? ((int'(limit) > 99) ? 99 : int'(limit)) : m_lim;
      n_count   = m_count;
      rev       = 0;
      if (m_tick && ena) begin
        if (m_up) begin
          if (m_count < m_lim) n_count = m_count + 1;
          else if (mode == 2'b01) begin n_count = (m_lim == 0) ? 0 : m_lim - 1; rev = 1; end
          else if (mode == 2'b10) n_count = m_lim;
          else n_count = 0;
        end else begin
          if (m_count > 0) n_count = m_count - 1;
          else if (mode == 2'b01) begin n_count = (m_lim == 0) ? 0 : 1; rev = 1; end
          else if (mode == 2'b10) n_count = 0;
          else n_count = m_lim;
        end
      end
      n_up   = (edge_seen || rev) ? !m_up : m_up;
      n_disp = {seg_tab[(m_count / 10) % 10], seg_tab[m_count % 10]};
    end
    @(posedge clk_50MHz);
    #1;
    m_dtq   = rst ? 1'b0 : dir_toggle;
    m_phase = n_phase; m_tick = n_tick; m_count = n_count;
    m_up    = n_up;    m_lim  = n_lim;  m_disp  = n_disp;
    chk("count",    32'(count),    32'(m_count));
    chk("count_up", 32'(count_up), 32'(m_up));
    chk("tick",     32'(tick),     32'(m_tick));
    chk("at_limit", 32'(at_limit), 32'(m_count >= m_lim));
    chk("at_zero",  32'(at_zero),  32'(m_count == 0));
    chk("disp",     32'(disp),     32'(m_disp));
  endtask

  initial begin
    int saved;
    bit hit;

    // 1: reset for two cycles, then release with ena high
    step(); step();
    chk("rst_disp_blank", 32'(disp), 32'h3FFF);
    chk("rst_count_zero", 32'(count), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();

    // 2: wrap at limit 5
    limit = 6'd5; load_limit = 1'b1; mode = 2'b00;
    step();
    load_limit = 1'b0;
    for (int i = 0; i < 24; i++) step();

    // 3: bounce at limit 3
    limit = 6'd3; load_limit = 1'b1; mode = 2'b01;
    step();
    load_limit = 1'b0;
    for (int i = 0; i < 27; i++) step();

    // 4: stop mode, one toggle while climbing through 2
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      hit = (m_count == 2) && m_up;
    end
    chk("reach_cnt2_up", 32'(hit), 32'd1);
    mode = 2'b10; dir_toggle = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("stop_at_zero", 32'(at_zero), 32'd1);
    chk("stop_dir_down", 32'(count_up), 32'd0);

    // 5: wrap up to 4 with limit 9, then lower the limit below the count
    mode = 2'b00; dir_toggle = 1'b0; limit = 6'd9; load_limit = 1'b1;
    step();
    load_limit = 1'b0; dir_toggle = 1'b1;
    step();
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = (m_count == 4) && m_up;
    end
    chk("reach_cnt4", 32'(hit), 32'd1);
    limit = 6'd2; load_limit = 1'b1;
    step();
    load_limit = 1'b0;
    step(); step();
    chk("lowered_limit_wrap", 32'(count), 32'd0);

    // 6: enable low holds the count while ticks continue, then reset mid-count
    ena = 1'b0; saved = m_count;
    for (int i = 0; i < 30; i++) step();
    chk("ena_hold", 32'(count), 32'(saved));
    ena = 1'b1; limit = 6'd9; load_limit = 1'b1;
    step();
    load_limit = 1'b0;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = (m_count == 7);
    end
    chk("reach_cnt7", 32'(hit), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_up", 32'(count_up), 32'd1);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      ena        = ($urandom_range(0, 3) != 0);
      mode       = 2'($urandom_range(0, 3));
      load_limit = ($urandom_range(0, 15) == 0);
      limit      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) dir_toggle = ~dir_toggle;
      step();
    end
    rst = 1'b0; load_limit = 1'b0;

    // limit saturation on the 7-bit instance: load 120, count down from 0 in wrap
    b_rst = 1'b1;
    step();
    b_rst = 1'b0; b_load = 1'b1; b_limit = 7'd120; b_dt = 1'b1; b_mode = 2'b00; b_ena = 1'b1;
    step();
    b_load = 1'b0;
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      step();
      hit = (b_count != 7'd0);
    end
    chk("wide_step_seen", 32'(hit), 32'd1);
    chk("wide_clamp_count", 32'(b_count), 32'd99);
    chk("wide_dir_down", 32'(b_up), 32'd0);
    chk("wide_at_limit", 32'(b_atl), 32'd1);
    step();
    chk("wide_disp99", 32'(b_disp), 32'({seg_tab[9], seg_tab[9]}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
